mult_sequencer: RTL and testbench

- Upstream/downstream wrapper for the 32x32 shift-and-add multiplier.
- Buffers operand pairs arriving on a valid/ready stream in a small FIFO and drives the multiplier's start/ready handshake.
- Holds each operand pair stable for the whole operation, then captures the 64-bit product into a valid/ready output register.
- Detects a stalled multiplier through a watchdog and counts completed operations.

---
 rtl/mult_pkg.sv | 16 +
 rtl/mult_sequencer_if.sv | 34 +++
 rtl/mult_op_fifo.sv | 59 +++++
 rtl/mult_sequencer.sv | 166 ++++++++++++++++
 tb/tb_mult_sequencer.sv | 254 +++++++++++++++++++++++++
 5 files changed

// File: rtl/mult_pkg.sv
// Shared definitions for the multiplier sequencer slice.
// Contents: default operand width, default watchdog limit and the one-hot
// encoding of the sequencer FSM states.
package mult_pkg;

    localparam int unsigned DEF_WIDTH       = 32;
    localparam int unsigned DEF_TIMEOUT_CYC = 64;

    // One-hot so that each state decodes from a single flop.
    typedef enum logic [2:0] {
        ST_IDLE      = 3'b001,
        ST_ISSUE     = 3'b010,
        ST_WAIT_DONE = 3'b100
    } seq_state_e;

endpackage

// File: rtl/mult_sequencer_if.sv
// Bus bundle for mult_sequencer.
// Groups three handshakes:
//   in_*  : operand stream in (valid/ready, operands A and B)
//   out_* : product stream out (valid/ready, 2*WIDTH product)
//   mul_* : multiplier handshake (start/ready, operands out, product in)
// Modports:
//   slave  : the sequencer's view
//   master : the surrounding environment's view
interface mult_sequencer_if import mult_pkg::*; #(
    parameter int unsigned WIDTH = DEF_WIDTH
);
    logic               in_valid;
    logic               in_ready;
    logic [WIDTH-1:0]   in_a;
    logic [WIDTH-1:0]   in_b;
    logic               out_valid;
    logic               out_ready;
    logic [2*WIDTH-1:0] out_p;
    logic               mul_start;
    logic               mul_ready;
    logic [WIDTH-1:0]   mul_a;
    logic [WIDTH-1:0]   mul_b;
    logic [2*WIDTH-1:0] mul_p;

    modport slave (
        input  in_valid, in_a, in_b, out_ready, mul_ready, mul_p,
        output in_ready, out_valid, out_p, mul_start, mul_a, mul_b
    );

    modport master (
        output in_valid, in_a, in_b, out_ready, mul_ready, mul_p,
        input  in_ready, out_valid, out_p, mul_start, mul_a, mul_b
    );
endinterface

// File: rtl/mult_op_fifo.sv
// Operand-pair FIFO in front of the multiplier.
// DEPTH entries of 2*WIDTH bits ({a, b}). Pointers carry an extra wrap bit so
// that full and empty can be told apart when the index bits are equal.
// Ports:
//   clock, reset : clock and synchronous active-high reset
//   push/wr_data : write request and data (ignored when full)
//   pop/rd_data  : read request (ignored when empty) and head-of-queue data
//   full, empty  : occupancy flags, decoded from registered pointers
module mult_op_fifo import mult_pkg::*; #(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned DEPTH = 4
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               push,
    input  logic [2*WIDTH-1:0] wr_data,
    input  logic               pop,
    output logic [2*WIDTH-1:0] rd_data,
    output logic               full,
    output logic               empty
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    logic [2*WIDTH-1:0] mem_r [DEPTH];
    logic [PW-1:0]      wr_ptr_r;
    logic [PW-1:0]      rd_ptr_r;
    logic               wr_en_s;
    logic               rd_en_s;

    assign full    = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
                     (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
    assign empty   = (wr_ptr_r == rd_ptr_r);
    assign wr_en_s = push && !full;
    assign rd_en_s = pop && !empty;
    assign rd_data = mem_r[rd_ptr_r[AW-1:0]];

    // Read and write pointers; reset empties the queue.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_r <= {PW{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
        end else begin
            if (wr_en_s) begin
                wr_ptr_r <= wr_ptr_r + PW'(1);
            end
            if (rd_en_s) begin
                rd_ptr_r <= rd_ptr_r + PW'(1);
            end
        end
    end

    // Entry storage; contents are don't-care until written, so no reset.
    always_ff @(posedge clock) begin
        if (wr_en_s) begin
            mem_r[wr_ptr_r[AW-1:0]] <= wr_data;
        end
    end
endmodule

// File: rtl/mult_sequencer.sv
// Sequencer wrapping a shift-and-add multiplier.
// Queues operand pairs, issues them one at a time with a start/ready
// handshake, holds operands stable during the operation, captures the product
// into a valid/ready output register, aborts stalled operations via a
// watchdog and counts completed products.
// Ports:
//   clock, reset : clock and synchronous active-high reset (shared with the
//                  multiplier)
//   bus          : in_*/out_*/mul_* handshakes (slave modport)
//   busy         : high while an operation is in ISSUE or WAIT_DONE
//   timeout_err  : sticky watchdog flag
//   ops_done     : completed-product count, wraps
module mult_sequencer import mult_pkg::*; #(
    parameter int unsigned WIDTH       = DEF_WIDTH,
    parameter int unsigned DEPTH       = 4,
    parameter int unsigned TIMEOUT_CYC = DEF_TIMEOUT_CYC,
    parameter int unsigned CNT_W       = 16
) (
    input  logic                 clock,
    input  logic                 reset,
    mult_sequencer_if.slave      bus,
    output logic                 busy,
    output logic                 timeout_err,
    output logic [CNT_W-1:0]     ops_done
);
    localparam int unsigned WD_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYC - 1);

    seq_state_e         state_r,       state_nxt_s;
    logic               mul_start_r,   mul_start_nxt_s;
    logic [WIDTH-1:0]   mul_a_r,       mul_a_nxt_s;
    logic [WIDTH-1:0]   mul_b_r,       mul_b_nxt_s;
    logic               out_valid_r,   out_valid_nxt_s;
    logic [2*WIDTH-1:0] out_p_r,       out_p_nxt_s;
    logic [WD_W-1:0]    wd_r,          wd_nxt_s;
    logic               timeout_r,     timeout_nxt_s;
    logic [CNT_W-1:0]   ops_done_r,    ops_done_nxt_s;

    logic               push_s;
    logic               pop_s;
    logic               full_s;
    logic               empty_s;
    logic [2*WIDTH-1:0] head_s;

    assign push_s = bus.in_valid && !full_s;

    mult_op_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock   (clock),
        .reset   (reset),
        .push    (push_s),
        .wr_data ({bus.in_a, bus.in_b}),
        .pop     (pop_s),
        .rd_data (head_s),
        .full    (full_s),
        .empty   (empty_s)
    );

    // Next-state and next-register logic for the issue FSM and watchdog.
    always_comb begin
        state_nxt_s     = state_r;
        mul_start_nxt_s = mul_start_r;
        mul_a_nxt_s     = mul_a_r;
        mul_b_nxt_s     = mul_b_r;
        out_p_nxt_s     = out_p_r;
        wd_nxt_s        = wd_r;
        timeout_nxt_s   = timeout_r;
        ops_done_nxt_s  = ops_done_r;
        pop_s           = 1'b0;

        // Consumer handshake; IDLE below still sees the old out_valid_r, so an
        // accept in this cycle delays the next issue by one cycle.
        if (out_valid_r && bus.out_ready) begin
            out_valid_nxt_s = 1'b0;
        end else begin
            out_valid_nxt_s = out_valid_r;
        end

        case (state_r)
            ST_IDLE: begin
                mul_start_nxt_s = 1'b0;
                if (!empty_s && bus.mul_ready && !out_valid_r) begin
                    pop_s           = 1'b1;
                    mul_a_nxt_s     = head_s[2*WIDTH-1:WIDTH];
                    mul_b_nxt_s     = head_s[WIDTH-1:0];
                    mul_start_nxt_s = 1'b1;
                    wd_nxt_s        = {WD_W{1'b0}};
                    state_nxt_s     = ST_ISSUE;
                end else begin
                    state_nxt_s     = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                wd_nxt_s = wd_r + WD_W'(1);
                if (wd_r == WD_LAST) begin
                    // Watchdog expiry wins over any handshake this cycle.
                    mul_start_nxt_s = 1'b0;
                    timeout_nxt_s   = 1'b1;
                    state_nxt_s     = ST_IDLE;
                end else if (!bus.mul_ready) begin
                    mul_start_nxt_s = 1'b0;
                    state_nxt_s     = ST_WAIT_DONE;
                end else begin
                    mul_start_nxt_s = 1'b1;
                    state_nxt_s     = ST_ISSUE;
                end
            end
            ST_WAIT_DONE: begin
                mul_start_nxt_s = 1'b0;
                wd_nxt_s        = wd_r + WD_W'(1);
                if (wd_r == WD_LAST) begin
                    timeout_nxt_s = 1'b1;
                    state_nxt_s   = ST_IDLE;
                end else if (bus.mul_ready) begin
                    out_p_nxt_s     = bus.mul_p;
                    out_valid_nxt_s = 1'b1;
                    ops_done_nxt_s  = ops_done_r + CNT_W'(1);
                    state_nxt_s     = ST_IDLE;
                end else begin
                    state_nxt_s     = ST_WAIT_DONE;
                end
            end
            default: begin
                mul_start_nxt_s = 1'b0;
                state_nxt_s     = ST_IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            mul_start_r <= 1'b0;
            mul_a_r     <= {WIDTH{1'b0}};
            mul_b_r     <= {WIDTH{1'b0}};
            out_valid_r <= 1'b0;
            out_p_r     <= {(2*WIDTH){1'b0}};
            wd_r        <= {WD_W{1'b0}};
            timeout_r   <= 1'b0;
            ops_done_r  <= {CNT_W{1'b0}};
        end else begin
            state_r     <= state_nxt_s;
            mul_start_r <= mul_start_nxt_s;
            mul_a_r     <= mul_a_nxt_s;
            mul_b_r     <= mul_b_nxt_s;
            out_valid_r <= out_valid_nxt_s;
            out_p_r     <= out_p_nxt_s;
            wd_r        <= wd_nxt_s;
            timeout_r   <= timeout_nxt_s;
            ops_done_r  <= ops_done_nxt_s;
        end
    end

    assign bus.in_ready  = !full_s;
    assign bus.out_valid = out_valid_r;
    assign bus.out_p     = out_p_r;
    assign bus.mul_start = mul_start_r;
    assign bus.mul_a     = mul_a_r;
    assign bus.mul_b     = mul_b_r;
    assign busy          = (state_r == ST_ISSUE) || (state_r == ST_WAIT_DONE);
    assign timeout_err   = timeout_r;
    assign ops_done      = ops_done_r;
endmodule

// File: tb/tb_mult_sequencer.sv
// Directed bench for mult_sequencer with a behavioural multiplier stub:
// start seen on one edge, ready falls on the next, ready rises 33 edges later
// with the product. stub_mode pins mul_ready high and ignores start.
module tb_mult_sequencer;

    logic        clock;
    logic        reset;
    logic        busy;
    logic        timeout_err;
    logic [15:0] ops_done;
    logic        stub_mode;

    int checks;
    int errors;

    mult_sequencer_if #(.WIDTH(32)) bus ();

    mult_sequencer #(
        .WIDTH       (32),
        .DEPTH       (4),
        .TIMEOUT_CYC (64),
        .CNT_W       (16)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .bus         (bus),
        .busy        (busy),
        .timeout_err (timeout_err),
        .ops_done    (ops_done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Multiplier stub.
    logic        mdl_ready;
    logic        mdl_pend;
    logic [5:0]  mdl_cnt;
    logic [31:0] mdl_a;
    logic [31:0] mdl_b;
    logic [63:0] mdl_p;

    // Behavioural multiplier timing model.
    always @(posedge clock) begin
        if (reset) begin
            mdl_ready <= 1'b1;
            mdl_pend  <= 1'b0;
            mdl_cnt   <= 6'd0;
            mdl_a     <= 32'd0;
            mdl_b     <= 32'd0;
            mdl_p     <= 64'd0;
        end else if (mdl_pend) begin
            mdl_pend  <= 1'b0;
            mdl_ready <= 1'b0;
            mdl_cnt   <= 6'd0;
            mdl_a     <= bus.mul_a;
            mdl_b     <= bus.mul_b;
        end else if (!mdl_ready) begin
            if (mdl_cnt == 6'd32) begin
                mdl_ready <= 1'b1;
                mdl_p     <= {32'd0, mdl_a} * {32'd0, mdl_b};
            end else begin
                mdl_cnt <= mdl_cnt + 6'd1;
            end
        end else if (bus.mul_start && !stub_mode) begin
            mdl_pend <= 1'b1;
        end
    end

    assign bus.mul_ready = stub_mode ? 1'b1 : mdl_ready;
    assign bus.mul_p     = mdl_p;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [31:0] a, input logic [31:0] b);
        int n;
        n = 0;
        @(negedge clock);
        bus.in_valid = 1'b1;
        bus.in_a     = a;
        bus.in_b     = b;
        while (!bus.in_ready && n < 200) begin
            @(negedge clock);
            n++;
        end
        check("push_accept", 64'(bus.in_ready), 64'd1);
        @(posedge clock);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_product(input string tag, input logic [63:0] exp);
        int n;
        logic found;
        n = 0;
        found = 1'b0;
        while (!found && n < 300) begin
            @(posedge clock);
            #1;
            n++;
            if (bus.out_valid) found = 1'b1;
        end
        check({tag, "_valid"}, 64'(found), 64'd1);
        check(tag, bus.out_p, exp);
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1;
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
    endtask

    initial begin
        int   n;
        logic seen;
        checks        = 0;
        errors        = 0;
        reset         = 1'b1;
        stub_mode     = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_a      = 32'd0;
        bus.in_b      = 32'd0;
        bus.out_ready = 1'b1;

        // Reset state.
        repeat (3) @(posedge clock);
        #1;
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_out_p",     bus.out_p,          64'd0);
        check("rst_mul_start", 64'(bus.mul_start), 64'd0);
        check("rst_mul_a",     64'(bus.mul_a),     64'd0);
        check("rst_mul_b",     64'(bus.mul_b),     64'd0);
        check("rst_in_ready",  64'(bus.in_ready),  64'd1);
        check("rst_busy",      64'(busy),          64'd0);
        check("rst_timeout",   64'(timeout_err),   64'd0);
        check("rst_ops_done",  64'(ops_done),      64'd0);
        @(negedge clock);
        reset = 1'b0;

        // 3 x 5 latency: push at edge 0, out_valid after edge 37.
        push(32'd3, 32'd5);
        n = 0;
        while (!bus.out_valid && n < 200) begin
            @(posedge clock);
            #1;
            n++;
        end
        check("lat_edge",     64'(n),        64'd37);
        check("lat_product",  bus.out_p,     64'd15);
        check("lat_ops_done", 64'(ops_done), 64'd1);
        @(posedge clock);
        #1;
        check("lat_out_cleared", 64'(bus.out_valid), 64'd0);
        check("lat_busy_low",    64'(busy),          64'd0);

        // Extreme operands, in-order delivery.
        push(32'hFFFF_FFFF, 32'hFFFF_FFFF);
        push(32'h0000_0000, 32'h1234_5678);
        wait_product("max_product",  64'hFFFF_FFFE_0000_0001);
        wait_product("zero_product", 64'd0);
        check("ops_after_two", 64'(ops_done), 64'd3);

        // Back-pressure burst of five.
        do_reset();
        bus.out_ready = 1'b0;
        push(32'd2,  32'd3);
        push(32'd4,  32'd5);
        push(32'd6,  32'd7);
        push(32'd8,  32'd9);
        push(32'd10, 32'd11);
        @(negedge clock);
        check("burst_full", 64'(bus.in_ready), 64'd0);
        wait_product("burst_p0", 64'd6);
        repeat (60) @(posedge clock);
        #1;
        check("hold_valid", 64'(bus.out_valid), 64'd1);
        check("hold_p",     bus.out_p,          64'd6);
        check("hold_busy",  64'(busy),          64'd0);
        check("hold_full",  64'(bus.in_ready),  64'd0);
        @(negedge clock);
        bus.out_ready = 1'b1;
        wait_product("burst_p1", 64'd20);
        wait_product("burst_p2", 64'd42);
        wait_product("burst_p3", 64'd72);
        wait_product("burst_p4", 64'd110);
        check("burst_ops_done", 64'(ops_done), 64'd5);

        // Stuck multiplier: start high for 64 cycles, then abort.
        @(negedge clock);
        stub_mode = 1'b1;
        push(32'd9, 32'd9);
        n = 0;
        seen = 1'b0;
        while (!seen && n < 200) begin
            @(posedge clock);
            #1;
            if (bus.mul_start) n++;
            else seen = 1'b1;
        end
        check("wd_start_cycles", 64'(n),           64'd64);
        check("wd_timeout_err",  64'(timeout_err), 64'd1);
        check("wd_busy",         64'(busy),        64'd0);
        check("wd_no_valid",     64'(bus.out_valid), 64'd0);
        check("wd_ops_done",     64'(ops_done),    64'd5);
        @(negedge clock);
        stub_mode = 1'b0;
        push(32'd7, 32'd6);
        wait_product("post_wd_product", 64'd42);
        check("post_wd_ops",    64'(ops_done),    64'd6);
        check("post_wd_sticky", 64'(timeout_err), 64'd1);

        // Reset during WAIT_DONE with two entries queued.
        push(32'd1, 32'd1);
        push(32'd2, 32'd2);
        push(32'd3, 32'd3);
        n = 0;
        while (!(busy && !bus.mul_start) && n < 200) begin
            @(posedge clock);
            #1;
            n++;
        end
        check("mid_in_wait", 64'(busy && !bus.mul_start), 64'd1);
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;
        check("mid_rst_start",   64'(bus.mul_start), 64'd0);
        check("mid_rst_ready",   64'(bus.in_ready),  64'd1);
        check("mid_rst_valid",   64'(bus.out_valid), 64'd0);
        check("mid_rst_ops",     64'(ops_done),      64'd0);
        check("mid_rst_timeout", 64'(timeout_err),   64'd0);
        @(negedge clock);
        reset = 1'b0;
        seen = 1'b0;
        repeat (100) begin
            @(posedge clock);
            #1;
            if (bus.out_valid || bus.mul_start || busy) seen = 1'b1;
        end
        check("mid_rst_quiet", 64'(seen), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
